dense_layer_engine: RTL and testbench

//  Runtime-programmable, time-multiplexed fully-connected layer: y[o] = act(sum_i W[o][i]*x[i] + b[o]).

---
 rtl/dense_layer_engine.sv | 165 ++++++++++++++++
 tb/tb_dense_layer_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_engine.sv
// Time-multiplexed fully-connected layer with runtime-loaded weight/bias RAMs.
// PAR neurons accumulate per MAC pass; results stream one per valid/ready handshake.
module dense_layer_engine #(
  parameter int N_IN   = 32,
  parameter int N_OUT  = 32,
  parameter int PAR    = 4,
  parameter int W_BITS = 4,
  parameter int W_INT  = 2,
  parameter int D_BITS = 16,
  parameter int D_INT  = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            relu_en,
  input  logic                            cfg_we,
  input  logic                            cfg_bias,
  input  logic [$clog2(N_IN*N_OUT)-1:0]   cfg_addr,
  input  logic [W_BITS-1:0]               cfg_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [N_IN*D_BITS-1:0]          in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [D_BITS-1:0]               out_data,
  output logic [$clog2(N_OUT)-1:0]        out_idx,
  output logic                            out_last,
  output logic                            busy
);
  localparam int WF = W_BITS - W_INT;
  localparam int DF = D_BITS - D_INT;
  localparam int PB = W_BITS + D_BITS;
  localparam int AW = W_BITS + D_BITS + $clog2(N_IN) + 1;
  localparam int NG = N_OUT / PAR;
  localparam int WA = $clog2(N_IN*N_OUT);
  localparam int OA = $clog2(N_OUT);
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int GW = (NG > 1) ? $clog2(NG) : 1;
  localparam int PW = (PAR > 1) ? $clog2(PAR) : 1;
  localparam logic signed [AW-1:0] DMAX = $signed({{(AW-D_BITS+1){1'b0}}, {(D_BITS-1){1'b1}}});
  localparam logic signed [AW-1:0] DMIN = $signed({{(AW-D_BITS+1){1'b1}}, {(D_BITS-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

  state_t                   state;
  logic [W_BITS-1:0]        wram [N_IN*N_OUT];
  logic [W_BITS-1:0]        bram [N_OUT];
  logic [N_IN*D_BITS-1:0]   x_reg;
  logic                     relu_reg;
  logic [IW-1:0]            i;
  logic [GW-1:0]            g;
  logic [PW-1:0]            e;
  logic signed [AW-1:0]     acc [PAR];
  logic signed [AW-1:0]     acc_next [PAR];
  logic signed [D_BITS-1:0] xi;

  function automatic logic signed [AW-1:0] align_bias(input logic [W_BITS-1:0] b);
    return {{(AW-W_BITS-DF){b[W_BITS-1]}}, b, {DF{1'b0}}};
  endfunction

  function automatic logic signed [AW-1:0] mul_ext(input logic signed [W_BITS-1:0] w,
                                                   input logic signed [D_BITS-1:0] x);
    logic signed [PB-1:0] pr;
    pr = w * x;
    return {{(AW-PB){pr[PB-1]}}, pr};
  endfunction

  function automatic logic [D_BITS-1:0] post(input logic signed [AW-1:0] a, input logic relu);
    logic signed [AW-1:0] s;
    s = a >>> WF;
    if (relu && s[AW-1]) return '0;
    if (s > DMAX) return {1'b0, {(D_BITS-1){1'b1}}};
    if (s < DMIN) return {1'b1, {(D_BITS-1){1'b0}}};
    return s[D_BITS-1:0];
  endfunction

  function automatic logic [WA-1:0] waddr(input int gg, input int pp, input int ii);
    return WA'((gg*PAR + pp)*N_IN + ii);
  endfunction

  function automatic logic [OA-1:0] oaddr(input int gg, input int pp);
    return OA'(gg*PAR + pp);
  endfunction

  // Bias is folded in on the first MAC step, so a config write on the accept cycle is seen.
  always_comb begin
    xi = x_reg[int'(i)*D_BITS +: D_BITS];
    for (int p = 0; p < PAR; p++) begin
      acc_next[p] = ((i == '0) ? align_bias(bram[oaddr(int'(g), p)]) : acc[p])
                  + mul_ext(wram[waddr(int'(g), p, int'(i))], xi);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && cfg_we && state == IDLE) begin
      if (!cfg_bias) wram[cfg_addr] <= cfg_data;
      else if (int'(cfg_addr) < N_OUT) bram[OA'(cfg_addr)] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      g         <= '0;
      i         <= '0;
      e         <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x_reg    <= in_data;
            relu_reg <= relu_en;
            g        <= '0;
            i        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          for (int p = 0; p < PAR; p++) acc[p] <= acc_next[p];
          if (i == IW'(N_IN-1)) begin
            i         <= '0;
            e         <= '0;
            out_valid <= 1'b1;
            out_data  <= post(acc_next[0], relu_reg);
            out_idx   <= oaddr(int'(g), 0);
            out_last  <= (int'(g)*PAR == N_OUT-1);
            state     <= EMIT;
          end else begin
            i <= i + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (e == PW'(PAR-1)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (g == GW'(NG-1)) begin
                busy     <= 1'b0;
                in_ready <= 1'b1;
                state    <= IDLE;
              end else begin
                g     <= g + 1'b1;
                state <= MAC;
              end
            end else begin
              e        <= e + 1'b1;
              out_data <= post(acc[e + 1'b1], relu_reg);
              out_idx  <= oaddr(int'(g), int'(e) + 1);
              out_last <= (int'(g)*PAR + int'(e) + 1 == N_OUT-1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed + randomized bench for dense_layer_engine against an integer reference model.
module tb_dense_layer_engine;
  localparam int N_IN = 32, N_OUT = 32, PAR = 4, W_BITS = 4, D_BITS = 16;
  localparam int AB = $clog2(N_IN*N_OUT), OB = $clog2(N_OUT);

  logic clk = 0, reset = 1, relu_en = 0, cfg_we = 0, cfg_bias = 0;
  logic [AB-1:0] cfg_addr = '0;
  logic [W_BITS-1:0] cfg_data = '0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_last, busy;
  logic [N_IN*D_BITS-1:0] in_data = '0;
  logic [D_BITS-1:0] out_data;
  logic [OB-1:0] out_idx;

  int tests = 0, fails = 0, cyc = 0;
  int mw [N_OUT][N_IN];
  int mb [N_OUT];
  int xv [N_IN];

  dense_layer_engine dut (
    .clk(clk), .reset(reset), .relu_en(relu_en), .cfg_we(cfg_we), .cfg_bias(cfg_bias),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // y = sat((b*2^10 + sum w*x) / 4, floored), values in integer LSB units
  function automatic logic [15:0] ref_y(input int o, input bit relu);
    int s;
    s = mb[o] * 1024;
    for (int k = 0; k < N_IN; k++) s += mw[o][k] * xv[k];
    s = s >>> 2;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic wcfg(input bit b, input int addr, input int val);
    cfg_we = 1; cfg_bias = b; cfg_addr = AB'(addr); cfg_data = W_BITS'(val);
    tick();
    cfg_we = 0;
  endtask

  task automatic set_w(input int o, input int k, input int v);
    wcfg(0, o*N_IN + k, v); mw[o][k] = v;
  endtask

  task automatic set_b(input int o, input int v);
    wcfg(1, o, v); mb[o] = v;
  endtask

  task automatic load_all(input int wv, input int bv, input bit rnd);
    for (int o = 0; o < N_OUT; o++)
      for (int k = 0; k < N_IN; k++)
        set_w(o, k, rnd ? int'($urandom_range(0, 15)) - 8 : wv);
    for (int o = 0; o < N_OUT; o++) set_b(o, rnd ? int'($urandom_range(0, 15)) - 8 : bv);
  endtask

  task automatic set_x(input int v, input int span);
    for (int k = 0; k < N_IN; k++) begin
      xv[k] = (span > 0) ? int'($urandom_range(0, 2*span - 1)) - span : v;
      in_data[k*D_BITS +: D_BITS] = D_BITS'(xv[k]);
    end
  endtask

  task automatic send(input bit relu, input bit cfg_on, input bit cb, input int ca, input int cv,
                      output int acc_cyc);
    int n = 0;
    relu_en = relu; in_valid = 1;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("accept_ready", in_ready, 1);
    if (cfg_on) begin
      cfg_we = 1; cfg_bias = cb; cfg_addr = AB'(ca); cfg_data = W_BITS'(cv);
    end
    acc_cyc = cyc;
    tick();
    cfg_we = 0; in_valid = 0;
    relu_en = ~relu;
  endtask

  // mode 0: ready held high (timing checked); mode 1: random ready
  task automatic collect(input bit relu, input int acc_cyc, input int mode, input int stall_idx);
    logic [15:0] exp_y [N_OUT];
    logic [15:0] hd;
    logic [OB-1:0] hi;
    int k = 0, guard = 0, first = -1, last_c = -1;
    bit stalled = 0;
    for (int o = 0; o < N_OUT; o++) exp_y[o] = ref_y(o, relu);
    out_ready = 1;
    while (k < N_OUT && guard < 3000) begin
      if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && !stalled && stall_idx >= 0 && int'(out_idx) == stall_idx) begin
        stalled = 1; out_ready = 0; hd = out_data; hi = out_idx;
        repeat (10) begin
          tick();
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, hd);
          check("stall_idx", out_idx, hi);
        end
        out_ready = 1;
      end
      if (out_valid && out_ready) begin
        if (first < 0) first = cyc;
        check("out_idx", out_idx, k);
        check("out_data", out_data, exp_y[k]);
        check("out_last", out_last, (k == N_OUT-1));
        last_c = cyc;
        k++;
      end
      tick();
      guard++;
    end
    check("all_outputs", k, N_OUT);
    if (mode == 0 && stall_idx < 0) begin
      check("latency", first - acc_cyc, N_IN + 1);
      check("duration", last_c - acc_cyc, (N_OUT/PAR)*(N_IN+PAR));
    end
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
  endtask

  initial begin
    int c, nv;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // all-ones weights saturate positive
    load_all(4, 0, 0);
    set_x(1024, 0);
    send(0, 0, 0, 0, 0, c); collect(0, c, 0, -1);
    // downstream stall on idx 5
    send(0, 0, 0, 0, 0, c); collect(0, c, 0, 5);

    // negative weights, with and without relu
    load_all(-4, 0, 0);
    send(0, 0, 0, 0, 0, c); collect(0, c, 0, -1);
    send(1, 0, 0, 0, 0, c); collect(1, c, 0, -1);

    // bias only
    load_all(0, 7, 0);
    send(0, 0, 0, 0, 0, c); collect(0, c, 0, -1);
    for (int o = 0; o < N_OUT; o++) set_b(o, -8);
    send(0, 0, 0, 0, 0, c); collect(0, c, 1, -1);

    // reset mid-MAC of group 1 (i=7), then reuse retained weights
    load_all(4, 0, 0);
    send(0, 0, 0, 0, 0, c);
    out_ready = 1;
    while (cyc < c + 44) tick();
    reset = 1;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    reset = 0;
    nv = 0;
    repeat (40) begin tick(); if (out_valid) nv++; end
    check("midrst_no_valid", nv, 0);
    send(0, 0, 0, 0, 0, c); collect(0, c, 0, -1);

    // config writes while busy are dropped; in IDLE they land
    send(0, 0, 0, 0, 0, c);
    tick(); wcfg(0, 0, 7); wcfg(1, 0, 7);
    collect(0, c, 0, -1);
    set_w(0, 0, 7);
    send(0, 0, 0, 0, 0, c); collect(0, c, 0, -1);

    // random weights/data; bias write on the accept cycle must be used
    load_all(0, 0, 1);
    set_x(0, 512);
    xv[0] = 256; in_data[0 +: D_BITS] = 16'd256;
    mb[1] = (mb[1] == 3) ? -5 : 3;
    send(0, 1, 1, 1, mb[1], c); collect(0, c, 1, -1);
    send(1, 0, 0, 0, 0, c);
    tick(); wcfg(0, 0, (mw[0][0] == 7) ? -8 : 7); wcfg(1, 0, (mb[0] == 7) ? -8 : 7);
    collect(1, c, 0, -1);
    set_x(0, 4096);
    send(0, 0, 0, 0, 0, c); collect(0, c, 1, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
